// File: rtl/router_pkg.sv
// Shared constants for the router output-port FIFOs: geometry, pointer width,
// packet counter width and the position of the payload-length field in a header.
package router_pkg;

    localparam int FIFO_DEPTH  = 16;
    localparam int ENTRY_WIDTH = 9;
    localparam int PTR_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W       = 7;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;

    // Bytes still to deliver once a header leaves the FIFO: payload plus parity.
    function automatic logic [CNT_W-1:0] pkt_len(input logic [7:0] hdr);
        return CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// One output-port FIFO of the router: stores {header flag, byte} entries and
// tracks the packet being drained so data_out idles at zero between packets.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = ENTRY_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       soft_reset,
    input  logic       write_enb,
    input  logic       read_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       data_out_q, data_out_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rd_entry;

    // Extra pointer MSB distinguishes a full wrap from an empty FIFO.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign data_out = data_out_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a value unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        mem_d      = mem_q;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) begin
                mem_d[wr_ptr_q[AW-1:0]] = WIDTH'({lfd_state, data_in});
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                data_out_d = rd_entry[7:0];
                if (rd_entry[WIDTH-1]) begin
                    count_d = pkt_len(rd_entry[7:0]);
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end else if (count_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            // NOTE: the storage array is reset as well because entries must read
            // back as zero after reset; soft_reset deliberately leaves it alone.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset/idle, a full packet,
// overflow, steady-state streaming, full/empty corner cases and flushes.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int passed = 0;
    int total  = 0;

    logic [7:0] parity;
    logic [4:0] occ;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic sr, input logic we, input logic re,
                        input logic lfd, input logic [7:0] din);
        reset      = rst;
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'h00);
        check("rst_count", 32'(dut.count_q), 32'd0);
        check("rst_mem0", 32'(dut.mem_q[0]), 32'h000);

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 8'h00);
            check("idle_empty", 32'(empty), 32'd1);
            check("idle_full", 32'(full), 32'd0);
            check("idle_dout", 32'(data_out), 32'h00);
        end

        // Packet: header 8'h39 (len 14), 14 payloads, parity.
        parity = 8'h39;
        step(0, 0, 1, 0, 1, 8'h39);
        check("pkt_hdr_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 1, 0, 0, 8'h10 + 8'(i));
            parity = parity ^ (8'h10 + 8'(i));
        end
        check("pkt_not_full", 32'(full), 32'd0);
        step(0, 0, 1, 0, 0, parity);
        check("pkt_full", 32'(full), 32'd1);
        check("pkt_dout_before_read", 32'(data_out), 32'h00);

        step(0, 0, 0, 1, 0, 8'h00);
        check("pkt_rd_hdr", 32'(data_out), 32'h39);
        check("pkt_cnt_hdr", 32'(dut.count_q), 32'd15);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check("pkt_rd_payload", 32'(data_out), 32'(8'h10 + 8'(i)));
            check("pkt_cnt_payload", 32'(dut.count_q), 32'(14 - i));
        end
        step(0, 0, 0, 1, 0, 8'h00);
        check("pkt_rd_parity", 32'(data_out), 32'(parity));
        check("pkt_cnt_parity", 32'(dut.count_q), 32'd0);
        check("pkt_drained_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 0, 0, 8'h00);
        check("pkt_idle_dout", 32'(data_out), 32'h00);

        // Overflow: 17 writes, the last is dropped.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'hA0 + 8'(i));
        check("ovf_full16", 32'(full), 32'd1);
        step(0, 0, 1, 0, 0, 8'hEE);
        check("ovf_full17", 32'(full), 32'd1);
        occ = dut.wr_ptr_q - dut.rd_ptr_q;
        check("ovf_occ", 32'(occ), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check("ovf_rd", 32'(data_out), 32'(8'hA0 + 8'(i)));
        end
        check("ovf_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 1, 0, 8'h00);
        check("ovf_rd_empty_dout", 32'(data_out), 32'h00);

        // Streaming at occupancy 8 with pointer wrap.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 8'h50 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1, 0, 8'h60 + 8'(i));
            check("strm_rd", 32'(data_out), (i < 8) ? 32'(8'h50 + 8'(i)) : 32'(8'h60 + 8'(i - 8)));
            occ = dut.wr_ptr_q - dut.rd_ptr_q;
            check("strm_occ", 32'(occ), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check("strm_drain", 32'(data_out), 32'(8'h6C + 8'(i)));
        end
        check("strm_empty", 32'(empty), 32'd1);

        // Full with both enables: read only. Empty with both: write only.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'hC0 + 8'(i));
        check("fb_full", 32'(full), 32'd1);
        step(0, 0, 1, 1, 0, 8'hFF);
        check("fb_rd", 32'(data_out), 32'hC0);
        check("fb_full_fall", 32'(full), 32'd0);
        occ = dut.wr_ptr_q - dut.rd_ptr_q;
        check("fb_occ", 32'(occ), 32'd15);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check("fb_drain", 32'(data_out), 32'(8'hC0 + 8'(i)));
        end
        check("fb_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 0, 8'h42);
        check("eb_write_only", 32'(empty), 32'd0);
        check("eb_dout", 32'(data_out), 32'h00);
        step(0, 0, 0, 1, 0, 8'h00);
        check("eb_rd", 32'(data_out), 32'h42);
        check("eb_empty", 32'(empty), 32'd1);

        // Mid-packet soft_reset at occupancy 5 with reads active.
        step(0, 0, 1, 0, 1, 8'h39);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 8'h20 + 8'(i));
        step(0, 0, 0, 1, 0, 8'h00);
        check("sr_rd_hdr", 32'(data_out), 32'h39);
        step(0, 0, 0, 1, 0, 8'h00);
        check("sr_rd_p0", 32'(data_out), 32'h20);
        check("sr_cnt_pre", 32'(dut.count_q), 32'd14);
        occ = dut.wr_ptr_q - dut.rd_ptr_q;
        check("sr_occ_pre", 32'(occ), 32'd5);
        step(0, 1, 1, 1, 0, 8'h99);
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_dout", 32'(data_out), 32'h00);
        check("sr_cnt", 32'(dut.count_q), 32'd0);
        check("sr_full", 32'(full), 32'd0);

        // Write after flush lands in entry 0; reset then wins over soft_reset and write.
        step(0, 0, 1, 0, 0, 8'h77);
        check("sr_post_mem0", 32'(dut.mem_q[0]), 32'h077);
        step(1, 1, 1, 1, 1, 8'h55);
        check("rst_pri_mem0", 32'(dut.mem_q[0]), 32'h000);
        check("rst_pri_empty", 32'(empty), 32'd1);
        check("rst_pri_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        check("rst_pri_dout", 32'(data_out), 32'h00);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check("post_rst_dout", 32'(data_out), 32'h00);
            check("post_rst_empty", 32'(empty), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
